// File: rtl/ha.sv
// ha: bit-sliced half adder with zero-latency outputs, a registered copy,
// and a saturating count of cycles in which any lane carries.
module ha #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    output logic [WIDTH-1:0] Cout,
    output logic [WIDTH-1:0] Sum,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Clk,
    input  logic             Reset,
    output logic [WIDTH-1:0] CoutQ,
    output logic [WIDTH-1:0] SumQ,
    output logic [CNT_W-1:0] CarryCnt,
    input  logic             CntClr
);
    logic [WIDTH-1:0] sum_q, cout_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign Sum      = A ^ B;
    assign Cout     = A & B;
    assign SumQ     = sum_q;
    assign CoutQ    = cout_q;
    assign CarryCnt = cnt_q;

    // clear wins over increment; all-ones is the saturation point
    always_comb cnt_d = CntClr ? '0 : (|Cout && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sum_q  <= '0;
            cout_q <= '0;
            cnt_q  <= '0;
        end else begin
            sum_q  <= Sum;
            cout_q <= Cout;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ha.sv
// tb_ha: randomized scoreboard bench for ha at WIDTH=8, CNT_W=3.
module tb_ha;
    localparam int W = 8;
    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic clr = 1'b0;
    logic [W-1:0] cout, sum, coutq, sumq;
    logic [CW-1:0] cnt;

    typedef struct {
        logic [W-1:0]  s;
        logic [W-1:0]  c;
        logic [CW-1:0] n;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    int model_cnt = 0;

    ha #(.WIDTH(W), .CNT_W(CW)) dut (
        .Cout(cout), .Sum(sum), .A(a), .B(b), .Clk(clk), .Reset(rst),
        .CoutQ(coutq), .SumQ(sumq), .CarryCnt(cnt), .CntClr(clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: each lane is a 1-bit integer addition giving a 2-bit result
    task automatic lane_add(input logic [W-1:0] x, input logic [W-1:0] y,
                            output logic [W-1:0] s, output logic [W-1:0] c);
        for (int i = 0; i < W; i++) begin
            int t;
            t = int'(x[i]) + int'(y[i]);
            s[i] = (t % 2) == 1;
            c[i] = t >= 2;
        end
    endtask

    task automatic check_comb(input string tag);
        logic [W-1:0] s, c;
        lane_add(a, b, s, c);
        check({tag, ".Sum"}, 64'(sum), 64'(s));
        check({tag, ".Cout"}, 64'(cout), 64'(c));
    endtask

    task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y, input logic cl);
        exp_t e;
        @(negedge clk);
        a = x;
        b = y;
        clr = cl;
        #1;
        check_comb("comb");
        lane_add(x, y, e.s, e.c);
        if (cl) model_cnt = 0;
        else if (e.c != 0 && model_cnt < CMAX) model_cnt++;
        e.n = CW'(model_cnt);
        q.push_back(e);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries still pending", q.size());
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("SumQ", 64'(sumq), 64'(e.s));
                check("CoutQ", 64'(coutq), 64'(e.c));
                check("CarryCnt", 64'(cnt), 64'(e.n));
            end
        end
    end

    initial begin : driver
        logic [W-1:0] x, y;
        #1;
        check("rst.SumQ", 64'(sumq), 64'd0);
        check("rst.CoutQ", 64'(coutq), 64'd0);
        check("rst.CarryCnt", 64'(cnt), 64'd0);
        // truth table on every lane while reset holds the registers
        for (int p = 0; p < 4; p++) begin
            a = (p & 2) != 0 ? '1 : '0;
            b = (p & 1) != 0 ? '1 : '0;
            #1;
            check_comb("tt");
        end
        a = '0;
        b = '0;
        @(negedge clk);
        rst = 1'b0;

        apply(8'hFF, 8'hFF, 1'b0);
        apply(8'h00, 8'hFF, 1'b0);
        apply(8'b1100, 8'b1010, 1'b0);
        apply(8'hF0, 8'h0F, 1'b0);

        apply(8'hFF, 8'hFF, 1'b1);
        for (int k = 0; k < 9; k++) apply(8'h01, 8'h01, 1'b0);
        apply(8'hFF, 8'hFF, 1'b1);

        for (int k = 0; k < 10000; k++) begin
            x = W'($urandom);
            y = ($urandom_range(3) == 0) ? (W'($urandom) & ~x) : W'($urandom);
            apply(x, y, $urandom_range(15) == 0);
        end

        apply(8'h00, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) apply(8'hFF, 8'hFF, 1'b0);
        drain();
        check("pre.CoutQ", 64'(coutq), 64'hFF);
        check("pre.CarryCnt", 64'(cnt), 64'd5);
        rst = 1'b1;
        #1;
        check("arst.SumQ", 64'(sumq), 64'd0);
        check("arst.CoutQ", 64'(coutq), 64'd0);
        check("arst.CarryCnt", 64'(cnt), 64'd0);
        a = 8'h5A;
        b = 8'h3C;
        #1;
        check_comb("arst");
        @(posedge clk);
        #1;
        check("hold.CoutQ", 64'(coutq), 64'd0);
        check("hold.CarryCnt", 64'(cnt), 64'd0);
        a = '0;
        b = '0;
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        for (int k = 0; k < 20; k++) apply(W'($urandom), W'($urandom), 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end
endmodule
